// File: rtl/divmod_select_seq_pkg.sv
// ---------------------------------------------------------------------------
// divmod_select_seq_pkg
//
// Shared definitions for the multi-cycle signed divide/modulo select block:
//   - state_e       : controller states (IDLE, CALC, FIX, DONE)
//   - cnt_width_f   : width of the quotient-bit counter for a given data width
//   - all_ones_f    : all-ones pattern (-1), the divide-by-zero quotient
//   - most_neg_f    : most-negative two's complement value
//
// The constant functions return MAX_W-bit vectors.  Callers size-cast the
// result to their own DATAWIDTH, so one package serves every legal width.
// ---------------------------------------------------------------------------
package divmod_select_seq_pkg;

  // Widest operand the constant helpers are able to describe.
  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // The counter is loaded with w-1 and counts down to 0, so clog2(w) bits
  // are always enough.
  function automatic int cnt_width_f(input int w);
    return $clog2(w);
  endfunction

  // Low w bits set: -1 at width w.
  function automatic logic [MAX_W-1:0] all_ones_f(input int w);
    logic [MAX_W-1:0] v;
    v = '1;
    return v >> (MAX_W - w);
  endfunction

  // Only bit w-1 set: the most-negative value at width w.
  function automatic logic [MAX_W-1:0] most_neg_f(input int w);
    logic [MAX_W-1:0] v;
    v        = '0;
    v[w-1]   = 1'b1;
    return v;
  endfunction

endpackage : divmod_select_seq_pkg

// File: rtl/divmod_select_seq_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
//
// Unsigned restoring divider step engine.  A load captures the dividend into
// the quotient shift register, captures the divisor and clears the partial
// remainder.  Each step retires one quotient bit, MSB first, so DATAWIDTH
// steps after a load the quotient and remainder outputs hold the result.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   load      in   capture dividend/divisor and restart
//   step      in   advance one quotient bit
//   dividend  in   DATAWIDTH unsigned dividend
//   divisor   in   DATAWIDTH unsigned divisor
//   quotient  out  DATAWIDTH unsigned quotient
//   remainder out  DATAWIDTH unsigned remainder
//
// A zero divisor is not special-cased here: every trial subtraction
// succeeds, giving an all-ones quotient.  The caller owns the signed and
// divide-by-zero semantics.
// ---------------------------------------------------------------------------
module div_iter #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder
);

  localparam int W = DATAWIDTH;

  logic [W-1:0] quo_q;   // dividend bits shift out the top, quotient bits in at the bottom
  logic [W-1:0] rem_q;   // partial remainder, always < divisor between steps
  logic [W-1:0] dvs_q;   // captured divisor

  // The shifted partial remainder needs one extra bit.  Once the
  // subtraction succeeds, the difference is below the divisor, so its low
  // W bits are exact.
  logic [W:0]   shifted;
  logic         fits;
  logic [W-1:0] diff;

  assign shifted = {rem_q, quo_q[W-1]};
  assign fits    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[W-1:0] - dvs_q;

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= {quo_q[W-2:0], fits};
      rem_q <= fits ? diff : shifted[W-1:0];
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule : div_iter

// File: rtl/divmod_select_seq.sv
// ---------------------------------------------------------------------------
// divmod_select_seq
//
// Multi-cycle signed divide/modulo select:
//   e = a / b,  f = c / d,  g = a % b,  z = (g == zero) ? f : e
// Two iterative radix-2 restoring dividers run in lock-step on the operand
// magnitudes.  A final FIX cycle applies the signs and handles the
// divide-by-zero and most-negative/-1 corners.  It also does the compare
// and the select, and registers the result.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   operand set present
//   in_ready   out  block accepts an operand set (IDLE only)
//   a, b, c, d in   DATAWIDTH signed operands
//   zero       in   DATAWIDTH signed compare value for g
//   out_valid  out  result held on the outputs (DONE)
//   out_ready  in   consumer takes the result
//   z          out  selected quotient
//   rem        out  g = a % b
//   sel        out  1 when g == zero (z = f)
//   div0       out  b == 0 or d == 0 for this result
//
// Timing: the accept edge is followed by DATAWIDTH CALC edges, one FIX edge,
// then DONE.  Each result takes DATAWIDTH+3 cycles with out_ready held high.
// ---------------------------------------------------------------------------
module divmod_select_seq
  import divmod_select_seq_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] z,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 sel,
  output logic                 div0
);

  localparam int           W        = DATAWIDTH;
  localparam int           CW       = cnt_width_f(W);
  localparam logic [W-1:0] ALL_ONES = W'(all_ones_f(W));
  localparam logic [W-1:0] MOST_NEG = W'(most_neg_f(W));

  // -------------------------------------------------------------------------
  // Controller and latched operands
  // -------------------------------------------------------------------------
  state_e        state_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  a_q, b_q, c_q, d_q, zero_q;

  logic [W-1:0]  z_q, rem_q;
  logic          sel_q, div0_q;

  logic          load, step;

  assign load = (state_q == IDLE) && in_valid;
  assign step = (state_q == CALC);

  // -------------------------------------------------------------------------
  // Magnitudes feed the unsigned dividers.  The most-negative value negates
  // to itself, and that bit pattern is its correct unsigned magnitude.
  // -------------------------------------------------------------------------
  logic [W-1:0] a_mag, b_mag, c_mag, d_mag;

  assign a_mag = a[W-1] ? -a : a;
  assign b_mag = b[W-1] ? -b : b;
  assign c_mag = c[W-1] ? -c : c;
  assign d_mag = d[W-1] ? -d : d;

  logic [W-1:0] q_ab_mag, r_ab_mag;
  logic [W-1:0] q_cd_mag;
  logic [W-1:0] r_cd_mag_unused;  // f needs only its quotient

  div_iter #(.DATAWIDTH(W)) u_div_ab (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (q_ab_mag),
    .remainder (r_ab_mag)
  );

  div_iter #(.DATAWIDTH(W)) u_div_cd (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .dividend  (c_mag),
    .divisor   (d_mag),
    .quotient  (q_cd_mag),
    .remainder (r_cd_mag_unused)
  );

  // -------------------------------------------------------------------------
  // Signed correction, compare and select.  These read only latched values
  // and divider outputs, and are used only in FIX.
  // -------------------------------------------------------------------------
  logic         sa, sb, sc, sd;
  logic         b_is_zero, d_is_zero;
  logic         ab_ovf, cd_ovf;
  logic [W-1:0] e_d, f_d, g_d, z_d;
  logic         sel_d, div0_d;

  assign sa        = a_q[W-1];
  assign sb        = b_q[W-1];
  assign sc        = c_q[W-1];
  assign sd        = d_q[W-1];
  assign b_is_zero = (b_q == '0);
  assign d_is_zero = (d_q == '0);
  assign ab_ovf    = (a_q == MOST_NEG) && (b_q == ALL_ONES);
  assign cd_ovf    = (c_q == MOST_NEG) && (d_q == ALL_ONES);

  // NOTE: every signal driven here is given a value on entry, before the
  // corner-case overrides.  An override left off a path then cannot infer a
  // latch.
  always_comb begin
    e_d = (sa ^ sb) ? -q_ab_mag : q_ab_mag;
    g_d = sa        ? -r_ab_mag : r_ab_mag;
    f_d = (sc ^ sd) ? -q_cd_mag : q_cd_mag;

    if (b_is_zero) begin
      e_d = ALL_ONES;
      g_d = a_q;
    end else if (ab_ovf) begin
      // The magnitude path already wraps to this value.  Stating it here
      // keeps the corner visible.
      e_d = MOST_NEG;
      g_d = '0;
    end

    if (d_is_zero) begin
      f_d = ALL_ONES;
    end else if (cd_ovf) begin
      f_d = MOST_NEG;
    end

    sel_d  = (g_d == zero_q);
    z_d    = sel_d ? f_d : e_d;
    div0_d = b_is_zero || d_is_zero;
  end

  // -------------------------------------------------------------------------
  // FSM with registered result
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      zero_q  <= '0;
      z_q     <= '0;
      rem_q   <= '0;
      sel_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= c;
            d_q     <= d;
            zero_q  <= zero;
            cnt_q   <= CW'(W - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          // The dividers step on every CALC edge, including the edge where
          // the counter is 0.  That gives exactly W quotient bits.
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          z_q     <= z_d;
          rem_q   <= g_d;
          sel_q   <= sel_d;
          div0_q  <= div0_d;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready is held low while reset is asserted, even though the state
  // already reads IDLE.
  assign in_ready  = rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;
  assign rem       = rem_q;
  assign sel       = sel_q;
  assign div0      = div0_q;

endmodule : divmod_select_seq

// File: tb/tb_divmod_select_seq.sv
// ---------------------------------------------------------------------------
// tb_divmod_select_seq
//
// Bench for divmod_select_seq at DATAWIDTH = 8.  Every operand set pushes
// its expected result into a queue when it is driven.  The entry is popped
// and compared when out_valid appears.  Directed vectors carry hand-derived
// constants.  Random vectors use an integer reference model built on the
// language's truncating signed / and %.
// ---------------------------------------------------------------------------
module tb_divmod_select_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] z;
    logic [W-1:0] rem;
    logic         sel;
    logic         div0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0, zero = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] z, rem;
  logic         sel, div0;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  divmod_select_seq #(.DATAWIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .rem       (rem),
    .sel       (sel),
    .div0      (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] ta, tb, tc, td, tz);
    exp_t m;
    int ai, bi, ci, di, e, f, g;
    ai = int'($signed(ta));
    bi = int'($signed(tb));
    ci = int'($signed(tc));
    di = int'($signed(td));
    if (bi == 0) begin
      e = -1;
      g = ai;
    end else begin
      e = ai / bi;
      g = ai % bi;
    end
    f      = (di == 0) ? -1 : ci / di;
    m.rem  = W'(g);
    m.sel  = (W'(g) == tz);
    m.z    = m.sel ? W'(f) : W'(e);
    m.div0 = (bi == 0) || (di == 0);
    return m;
  endfunction

  // Drive one operand set and return the cycle count of its accept edge.
  task automatic send(input logic [W-1:0] ta, tb, tc, td, tz, input exp_t exp,
                      output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1 within 100 cycles", in_ready);
    end
    a = ta; b = tb; c = tc; d = td; zero = tz;
    in_valid = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (the accept edge counts as edge 1), compare the
  // scoreboard head, and optionally consume with out_ready held high.
  task automatic recv(input string name, input bit chk_lat, input bit consume,
                      output exp_t got_exp);
    int   n;
    exp_t e;
    n = 1;
    got_exp = '0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required 1 within 200 edges", name, out_valid);
      return;
    end
    if (chk_lat) begin
      checks++;
      if (n !== W + 2) begin
        errors++;
        $display("FAIL %s_latency: edges=%0d required %0d", name, n, W + 2);
      end
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue empty, required one entry", name);
      return;
    end
    e = sb_q.pop_front();
    got_exp = e;
    if (z !== e.z) begin
      errors++;
      $display("FAIL %s_z: got %h required %h", name, z, e.z);
    end
    checks++;
    if (rem !== e.rem) begin
      errors++;
      $display("FAIL %s_rem: got %h required %h", name, rem, e.rem);
    end
    checks++;
    if (sel !== e.sel) begin
      errors++;
      $display("FAIL %s_sel: got %b required %b", name, sel, e.sel);
    end
    checks++;
    if (div0 !== e.div0) begin
      errors++;
      $display("FAIL %s_div0: got %b required %b", name, div0, e.div0);
    end
    if (consume) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_consume: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({z, rem, sel, div0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: z=%h rem=%h sel=%b div0=%b required all 0", z, rem, sel, div0);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    int   acc;
    exp_t got;
    // 7/2=3 r1, -9/2=-4; g=1 != 0 -> z=e
    send(8'h07, 8'h02, 8'hF7, 8'h02, 8'h00, '{z:8'h03, rem:8'h01, sel:1'b0, div0:1'b0}, acc);
    recv("basic", 1'b1, 1'b1, got);
    // -8/4 r0, 100/-7=-14; g=0 == 0 -> z=f
    send(8'hF8, 8'h04, 8'h64, 8'hF9, 8'h00, '{z:8'hF2, rem:8'h00, sel:1'b1, div0:1'b0}, acc);
    recv("sel_f", 1'b1, 1'b1, got);
    // -7%2=-1 == -1 -> z=f=5/0=-1, div0
    send(8'hF9, 8'h02, 8'h05, 8'h00, 8'hFF, '{z:8'hFF, rem:8'hFF, sel:1'b1, div0:1'b1}, acc);
    recv("div0", 1'b0, 1'b1, got);
    // -128/-1 wraps to -128, g=0 != 5
    send(8'h80, 8'hFF, 8'h01, 8'h01, 8'h05, '{z:8'h80, rem:8'h00, sel:1'b0, div0:1'b0}, acc);
    recv("wrap", 1'b0, 1'b1, got);
    // a/b divide-by-zero: rem = dividend, e = -1
    send(8'h2A, 8'h00, 8'h09, 8'h03, 8'h11, '{z:8'hFF, rem:8'h2A, sel:1'b0, div0:1'b1}, acc);
    recv("div0_ab", 1'b0, 1'b1, got);
  endtask

  task automatic test_reset_mid_calc();
    int   acc;
    bit   stale;
    exp_t got;
    send(8'h32, 8'h07, 8'h05, 8'h02, 8'h00, model(8'h32, 8'h07, 8'h05, 8'h02, 8'h00), acc);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    sb_q.delete();  // the in-flight operation is discarded
    checks++;
    if ({z, rem, sel, div0, out_valid, in_ready} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: z=%h rem=%h sel=%b div0=%b ov=%b ir=%b required all 0",
               z, rem, sel, div0, out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL midreset_stale: out_valid seen=1 required 0 after reset");
    end
    send(8'h09, 8'h03, 8'h01, 8'h01, 8'h07, '{z:8'h03, rem:8'h00, sel:1'b0, div0:1'b0}, acc);
    recv("after_reset", 1'b1, 1'b1, got);
  endtask

  task automatic test_stall();
    int   acc, rel;
    exp_t held, got;
    out_ready = 1'b0;
    // 7/3=2 r1, 20/4=5; g=1 == 1 -> z=5
    send(8'h07, 8'h03, 8'h14, 8'h04, 8'h01, '{z:8'h05, rem:8'h01, sel:1'b1, div0:1'b0}, acc);
    recv("stall", 1'b1, 1'b0, held);
    for (int i = 0; i < 20; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      zero = W'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({z, rem, sel, div0, in_ready, out_valid} !== {held.z, held.rem, held.sel, held.div0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: z=%h rem=%h sel=%b div0=%b ir=%b ov=%b required %h %h %b %b 0 1",
                 i, z, rem, sel, div0, in_ready, out_valid, held.z, held.rem, held.sel, held.div0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rel = cyc;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    send(8'hEC, 8'h06, 8'h0B, 8'hFD, 8'h00, model(8'hEC, 8'h06, 8'h0B, 8'hFD, 8'h00), acc);
    checks++;
    if (acc - rel !== 1) begin
      errors++;
      $display("FAIL stall_accept_gap: cycles=%0d required 1", acc - rel);
    end
    recv("post_stall", 1'b1, 1'b1, got);
  endtask

  task automatic test_back_to_back();
    int           acc, prev;
    exp_t         e, got;
    logic [W-1:0] ta, tb, tc, td, tz;
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      ta = W'($urandom);
      tb = (i == 3) ? '0 : W'($urandom);
      tc = (i == 5) ? 8'h80 : W'($urandom);
      td = (i == 5) ? 8'hFF : ((i == 7) ? '0 : W'($urandom));
      e  = model(ta, tb, tc, td, 8'h00);
      // Odd iterations aim zero at g so that the f path is selected.
      tz = (i % 2 == 1) ? e.rem : W'($urandom);
      e  = model(ta, tb, tc, td, tz);
      send(ta, tb, tc, td, tz, e, acc);
      if (i > 0) begin
        checks++;
        if (acc - prev !== W + 3) begin
          errors++;
          $display("FAIL b2b_period[%0d]: cycles=%0d required %0d", i, acc - prev, W + 3);
        end
      end
      prev = acc;
      recv($sformatf("b2b%0d", i), 1'b1, 1'b1, got);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_calc();
    test_stall();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_divmod_select_seq
